// File: rtl/cpu_exec_pkg.sv
// rtl/cpu_exec_pkg.sv - shared types and default widths for the CPU execution controller
package cpu_exec_pkg;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_INSTR_W = 10;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_LOAD = 3'd3,
    ST_CRST = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD   = 3'd0,
    OP_RUN    = 3'd1,
    OP_STEP   = 3'd2,
    OP_HALT   = 3'd3,
    OP_CPURST = 3'd4
  } cmd_op_t;

endpackage

// File: rtl/cpu_exec_cycle_counter.sv
// rtl/cpu_exec_cycle_counter.sv - saturating executed-cycle counter with synchronous clear
module cpu_exec_cycle_counter
  import cpu_exec_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_exec_ctrl.sv
// rtl/cpu_exec_ctrl.sv - host command FSM gating CPU clock-enable, reset and program loads
// Breakpoint stop logic is compiled in with CPU_EXEC_CTRL_BKPT_EN.
module cpu_exec_ctrl
  import cpu_exec_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [DATA_W-1:0]  cmd_addr,
  input  logic [INSTR_W-1:0] cmd_data,
  input  logic [DATA_W-1:0]  pc,
  input  logic               bp_en,
  input  logic [DATA_W-1:0]  bp_addr,
  output logic               cpu_en,
  output logic               cpu_rst,
  output logic               prog_we,
  output logic [DATA_W-1:0]  prog_waddr,
  output logic [INSTR_W-1:0] prog_wdata,
  output logic               running,
  output logic               cmd_err,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   cycle_count
);

  state_t             r_state;
  logic               r_first;
  logic               r_cpu_rst;
  logic               r_prog_we;
  logic [DATA_W-1:0]  r_prog_waddr;
  logic [INSTR_W-1:0] r_prog_wdata;
  logic               r_running;
  logic               r_cmd_err;
  logic               r_bp_hit;
  logic               w_bp_stop;

`ifdef CPU_EXEC_CTRL_BKPT_EN
  // r_first masks the match on the first RUN cycle so a resume executes bp_addr
  assign w_bp_stop = (r_state == ST_RUN) && !r_first && bp_en && (pc == bp_addr);
`else
  logic w_unused_bp;
  assign w_bp_stop   = 1'b0;
  assign w_unused_bp = ^{bp_en, bp_addr, pc, r_first};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_cpu_rst    <= 1'b0;
      r_prog_we    <= 1'b0;
      r_prog_waddr <= '0;
      r_prog_wdata <= '0;
      r_running    <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_bp_hit     <= 1'b0;
    end else begin
      r_first   <= 1'b0;
      r_cpu_rst <= 1'b0;
      r_prog_we <= 1'b0;
      r_cmd_err <= 1'b0;
      r_bp_hit  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                r_state      <= ST_LOAD;
                r_prog_we    <= 1'b1;
                r_prog_waddr <= cmd_addr;
                r_prog_wdata <= cmd_data;
              end
              OP_RUN: begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
                r_first   <= 1'b1;
              end
              OP_STEP:   r_state <= ST_STEP;
              OP_HALT:   r_state <= ST_IDLE;
              OP_CPURST: begin
                r_state   <= ST_CRST;
                r_cpu_rst <= 1'b1;
              end
              default:   r_cmd_err <= 1'b1;
            endcase
          end
        end
        ST_RUN: begin
          r_bp_hit <= w_bp_stop;
          if (cmd_valid && (cmd_op == OP_CPURST)) begin
            r_state   <= ST_CRST;
            r_running <= 1'b0;
            r_cpu_rst <= 1'b1;
          end else if ((cmd_valid && (cmd_op == OP_HALT)) || w_bp_stop) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
          if (cmd_valid && (cmd_op != OP_HALT) && (cmd_op != OP_CPURST)) begin
            r_cmd_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cpu_exec_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (cpu_en),
    .i_clr   (r_state == ST_CRST),
    .o_count (cycle_count)
  );

  assign cmd_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign cpu_en     = (r_state == ST_STEP) || ((r_state == ST_RUN) && !w_bp_stop);
  assign cpu_rst    = r_cpu_rst;
  assign prog_we    = r_prog_we;
  assign prog_waddr = r_prog_waddr;
  assign prog_wdata = r_prog_wdata;
  assign running    = r_running;
  assign cmd_err    = r_cmd_err;
  assign bp_hit     = r_bp_hit;

endmodule
